// File: rtl/sm_conv_arbiter.sv
// sm_conv_arbiter: round-robin arbiter sharing one two's-complement to sign-magnitude converter
module sm_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_data,
    output logic [IDW-1:0]         resp_id,
    output logic                   resp_ovf
);
    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;
    state_t state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d, x_id_q, x_id_d, resp_id_q, resp_id_d, win, cand;
    logic [WIDTH-1:0] x_q, x_d, resp_data_q, resp_data_d, neg, conv;
    logic resp_valid_q, resp_valid_d, resp_ovf_q, resp_ovf_d, found, is_min;
    always_comb begin
        found = 1'b0;
        win = last_grant_q;
        cand = last_grant_q;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_grant_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win = cand;
            end
        end
    end
    assign neg = '0 - x_q;
    assign is_min = x_q == {1'b1, {(WIDTH-1){1'b0}}};
    // The most-negative value maps onto 100..0 naturally, since its negation is itself.
    assign conv = x_q[WIDTH-1] ? {1'b1, neg[WIDTH-2:0]} : x_q;
    assign req_ready = (state_q == IDLE && !rst && found) ? N_REQ'(1) << win : '0;
    always_comb begin
        state_d = state_q;
        last_grant_d = last_grant_q;
        x_d = x_q;
        x_id_d = x_id_q;
        resp_valid_d = resp_valid_q;
        resp_data_d = resp_data_q;
        resp_id_d = resp_id_q;
        resp_ovf_d = resp_ovf_q;
        case (state_q)
            IDLE: if (found) begin
                x_d = req_data[int'(win)*WIDTH +: WIDTH];
                x_id_d = win;
                last_grant_d = win;
                state_d = CONV;
            end
            CONV: begin
                resp_data_d = conv;
                resp_id_d = x_id_q;
                resp_ovf_d = is_min;
                resp_valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: if (resp_ready) begin
                resp_valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_grant_q <= IDW'(N_REQ - 1);
            x_q <= '0;
            x_id_q <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q <= '0;
            resp_id_q <= '0;
            resp_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_grant_q <= last_grant_d;
            x_q <= x_d;
            x_id_q <= x_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q <= resp_data_d;
            resp_id_q <= resp_id_d;
            resp_ovf_q <= resp_ovf_d;
        end
    end
    assign resp_valid = resp_valid_q;
    assign resp_data = resp_data_q;
    assign resp_id = resp_id_q;
    assign resp_ovf = resp_ovf_q;
endmodule

// File: tb/tb_sm_conv_arbiter.sv
// tb_sm_conv_arbiter: directed checks of sm_conv_arbiter with hand-computed expectations
module tb_sm_conv_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req_valid = 4'b1111;
    logic [15:0] req_data = '0;
    logic resp_ready = 1'b0;
    logic [3:0] req_ready;
    logic resp_valid;
    logic [3:0] resp_data;
    logic [1:0] resp_id;
    logic resp_ovf;
    int checks = 0;
    int failures = 0;
    logic [3:0] sm_tab [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                4'h8, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9};
    sm_conv_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .resp_ovf(resp_ovf)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic set_in(input logic [3:0] v, input logic [15:0] d, input logic rr);
        req_valid = v;
        req_data = d;
        resp_ready = rr;
        #1;
    endtask
    initial begin
        for (int c = 0; c < 2; c++) begin
            tick;
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_valid", 32'(resp_valid), 0);
            chk("rst_data", 32'(resp_data), 0);
            chk("rst_id", 32'(resp_id), 0);
            chk("rst_ovf", 32'(resp_ovf), 0);
        end
        rst = 1'b0;
        set_in(4'b0000, 16'h0000, 1'b0);
        chk("post_rst_ready", 32'(req_ready), 0);
        tick;
        set_in(4'b0100, 16'h0B00, 1'b0);
        chk("single_grant", 32'(req_ready), 32'b0100);
        tick;
        set_in(4'b0000, 16'h0000, 1'b0);
        chk("single_conv_valid", 32'(resp_valid), 0);
        chk("single_conv_ready", 32'(req_ready), 0);
        tick;
        chk("single_valid", 32'(resp_valid), 1);
        chk("single_data", 32'(resp_data), 32'hD);
        chk("single_id", 32'(resp_id), 2);
        chk("single_ovf", 32'(resp_ovf), 0);
        set_in(4'b0000, 16'h0000, 1'b1);
        tick;
        chk("single_drop", 32'(resp_valid), 0);
        for (int v = 0; v < 16; v++) begin
            set_in(4'b0001, 16'(v), 1'b1);
            chk($sformatf("sweep_grant_%0d", v), 32'(req_ready), 32'b0001);
            tick;
            tick;
            chk($sformatf("sweep_valid_%0d", v), 32'(resp_valid), 1);
            chk($sformatf("sweep_data_%0d", v), 32'(resp_data), 32'(sm_tab[v]));
            chk($sformatf("sweep_ovf_%0d", v), 32'(resp_ovf), (v == 8) ? 1 : 0);
            tick;
        end
        rst = 1'b1;
        set_in(4'b0000, 16'h0000, 1'b1);
        tick;
        rst = 1'b0;
        for (int g = 0; g < 6; g++) begin
            set_in(4'b1111, 16'h4321, 1'b1);
            chk($sformatf("rr_grant_%0d", g), 32'(req_ready), 32'(1 << (g % 4)));
            tick;
            chk($sformatf("rr_conv_ready_%0d", g), 32'(req_ready), 0);
            tick;
            chk($sformatf("rr_resp_ready_%0d", g), 32'(req_ready), 0);
            chk($sformatf("rr_id_%0d", g), 32'(resp_id), 32'(g % 4));
            chk($sformatf("rr_data_%0d", g), 32'(resp_data), 32'(g % 4 + 1));
            tick;
        end
        set_in(4'b1010, 16'h4321, 1'b1);
        chk("rr_skip_grant", 32'(req_ready), 32'b1000);
        tick;
        tick;
        chk("rr_skip_id", 32'(resp_id), 3);
        tick;
        rst = 1'b1;
        set_in(4'b0000, 16'h0000, 1'b0);
        tick;
        rst = 1'b0;
        set_in(4'b1111, 16'h0009, 1'b0);
        chk("bp_grant", 32'(req_ready), 32'b0001);
        tick;
        tick;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid_%0d", c), 32'(resp_valid), 1);
            chk($sformatf("bp_data_%0d", c), 32'(resp_data), 32'hF);
            chk($sformatf("bp_id_%0d", c), 32'(resp_id), 0);
            chk($sformatf("bp_ovf_%0d", c), 32'(resp_ovf), 0);
            chk($sformatf("bp_ready_%0d", c), 32'(req_ready), 0);
            tick;
        end
        set_in(4'b1111, 16'h0009, 1'b1);
        chk("bp_release_valid", 32'(resp_valid), 1);
        tick;
        chk("bp_drop", 32'(resp_valid), 0);
        chk("bp_next_grant", 32'(req_ready), 32'b0010);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_in(4'b0010, 16'h00E0, 1'b1);
        chk("mid_grant", 32'(req_ready), 32'b0010);
        tick;
        chk("mid_conv_valid", 32'(resp_valid), 0);
        rst = 1'b1;
        set_in(4'b1111, 16'h00E0, 1'b1);
        chk("mid_rst_ready", 32'(req_ready), 0);
        tick;
        rst = 1'b0;
        #1;
        chk("mid_after_valid", 32'(resp_valid), 0);
        chk("mid_after_grant", 32'(req_ready), 32'b0001);
        tick;
        chk("mid_conv2_valid", 32'(resp_valid), 0);
        tick;
        chk("mid_resp_valid", 32'(resp_valid), 1);
        chk("mid_resp_id", 32'(resp_id), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
